// File: rtl/nas_vid_timing_if.sv
// ---------------------------------------------------------------------------
// nas_vid_timing_if
//   Bundle between the NASCOM raster timing generator and the character
//   ROM / shifter stage that consumes its strobes and addresses.
//
//   sel_60hz    : 1 = 60Hz line count (driven by the consumer side)
//   char_load   : one-clk strobe at the start of every character slot
//   vid_addr    : video RAM address (0 while blanked)
//   scan_line   : glyph scan line within the text row (0 while blanked)
//   active_h/v  : inside the displayed slots / lines
//   active      : active_h & active_v
//   hsync_n, vsync_n, csync_n : active-low syncs
//   frame_start : one-clk pulse at line 0, slot 0
//   blink       : slow blink timebase
//
//   master = timing generator, slave = video consumer.
// ---------------------------------------------------------------------------
interface nas_vid_timing_if;
  logic       sel_60hz;
  logic       char_load;
  logic [9:0] vid_addr;
  logic [3:0] scan_line;
  logic       active_h;
  logic       active_v;
  logic       active;
  logic       hsync_n;
  logic       vsync_n;
  logic       csync_n;
  logic       frame_start;
  logic       blink;

  modport master (
    input  sel_60hz,
    output char_load, vid_addr, scan_line, active_h, active_v, active,
           hsync_n, vsync_n, csync_n, frame_start, blink
  );

  modport slave (
    output sel_60hz,
    input  char_load, vid_addr, scan_line, active_h, active_v, active,
           hsync_n, vsync_n, csync_n, frame_start, blink
  );
endinterface

// File: rtl/nas_vid_timing.sv
// ---------------------------------------------------------------------------
// nas_vid_timing
//   Raster timing generator for the NASCOM video path on the 16MHz clock.
//   Walks char-slot / line / frame counters and produces char-slot strobes,
//   the rotated video RAM address, glyph scan line, blanking, H/V/composite
//   sync, a frame pulse and a blink timebase.
//
//   Ports:
//     clk     : 16MHz system clock
//     reset_n : asynchronous active-low reset
//     vt      : nas_vid_timing_if.master (sel_60hz in, all timing outputs)
//
//   Every output is registered from the counter state, so all outputs lag
//   the counters by one clk and stay aligned with one another.
// ---------------------------------------------------------------------------
module nas_vid_timing #(
  parameter int CLKS_PER_CHAR = 16,
  parameter int H_TOTAL       = 64,
  parameter int H_ACTIVE      = 48,
  parameter int HSYNC_START   = 52,
  parameter int HSYNC_WIDTH   = 5,
  parameter int SCANS_PER_ROW = 14,
  parameter int ROWS          = 16,
  parameter int V_TOTAL_50    = 312,
  parameter int V_TOTAL_60    = 262,
  parameter int VSYNC_START   = 240,
  parameter int VSYNC_WIDTH   = 4,
  parameter int ROW_STRIDE    = 64,
  parameter int TOP_ROW       = 15,
  parameter int BLINK_FRAMES  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  nas_vid_timing_if.master vt
);

  localparam int V_MAX        = (V_TOTAL_50 > V_TOTAL_60) ? V_TOTAL_50 : V_TOTAL_60;
  localparam int V_MIN        = (V_TOTAL_50 < V_TOTAL_60) ? V_TOTAL_50 : V_TOTAL_60;
  localparam int ACTIVE_LINES = ROWS * SCANS_PER_ROW;
  localparam int CC_W = (CLKS_PER_CHAR > 1) ? $clog2(CLKS_PER_CHAR) : 1;
  localparam int HC_W = (H_TOTAL > 1)       ? $clog2(H_TOTAL)       : 1;
  localparam int VC_W = (V_MAX > 1)         ? $clog2(V_MAX)         : 1;
  localparam int SC_W = (SCANS_PER_ROW > 1) ? $clog2(SCANS_PER_ROW) : 1;
  localparam int MR_W = (ROWS > 1)          ? $clog2(ROWS)          : 1;
  localparam int BF_W = (BLINK_FRAMES > 1)  ? $clog2(BLINK_FRAMES)  : 1;

  // Reject geometries whose sync windows or active regions do not fit the
  // totals, or whose addresses / scan lines overflow the output ports.
  generate
    if ((HSYNC_START + HSYNC_WIDTH > H_TOTAL) || (H_ACTIVE > H_TOTAL) ||
        (VSYNC_START + VSYNC_WIDTH > V_MIN) || (ACTIVE_LINES > V_MIN) ||
        (TOP_ROW >= ROWS) || (SCANS_PER_ROW > 16) ||
        ((ROWS - 1) * ROW_STRIDE + H_TOTAL - 1 > 1023)) begin : g_bad_geometry
      $error("nas_vid_timing: sync/active windows or address range do not fit the raster");
    end
  endgenerate

  logic [CC_W-1:0] cc;
  logic [HC_W-1:0] hc;
  logic [VC_W-1:0] vc;
  logic [VC_W-1:0] v_last;
  logic [SC_W-1:0] scan;
  logic [MR_W-1:0] mem_row;
  logic [BF_W-1:0] frame_cnt;
  logic            blink_state;

  logic cc_wrap, line_end, frame_end;
  logic in_h, in_v, in_hs, in_vs;
  logic [9:0] addr_next;

  assign cc_wrap   = (cc == CC_W'(CLKS_PER_CHAR - 1));
  assign line_end  = cc_wrap && (hc == HC_W'(H_TOTAL - 1));
  assign frame_end = line_end && (vc == v_last);

  assign in_h  = (32'(hc) < H_ACTIVE);
  assign in_v  = (32'(vc) < ACTIVE_LINES);
  assign in_hs = (32'(hc) >= HSYNC_START) && (32'(hc) < HSYNC_START + HSYNC_WIDTH);
  assign in_vs = (32'(vc) >= VSYNC_START) && (32'(vc) < VSYNC_START + VSYNC_WIDTH);

  assign addr_next = 10'(mem_row) * 10'(ROW_STRIDE) + 10'(hc);

  // Raster counters. Text row and scan line are stepped alongside the line
  // counter so no divider is needed; mem_row already carries the top-row
  // rotation. The frame length (v_last) is only reloaded on the frame's
  // final clk, so a mid-frame sel_60hz change waits for the next frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cc          <= '0;
      hc          <= '0;
      vc          <= '0;
      v_last      <= VC_W'(V_TOTAL_50 - 1);
      scan        <= '0;
      mem_row     <= MR_W'(TOP_ROW);
      frame_cnt   <= '0;
      blink_state <= 1'b0;
    end else begin
      cc <= cc_wrap ? '0 : cc + 1'b1;
      if (cc_wrap) begin
        hc <= (hc == HC_W'(H_TOTAL - 1)) ? '0 : hc + 1'b1;
      end
      if (frame_end) begin
        vc      <= '0;
        scan    <= '0;
        mem_row <= MR_W'(TOP_ROW);
        v_last  <= vt.sel_60hz ? VC_W'(V_TOTAL_60 - 1) : VC_W'(V_TOTAL_50 - 1);
        if (frame_cnt == BF_W'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_state <= ~blink_state;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end else if (line_end) begin
        vc <= vc + 1'b1;
        if (scan == SC_W'(SCANS_PER_ROW - 1)) begin
          scan    <= '0;
          mem_row <= (mem_row == MR_W'(ROWS - 1)) ? '0 : mem_row + 1'b1;
        end else begin
          scan <= scan + 1'b1;
        end
      end
    end
  end

  // Output stage: one register per output, all decoded from the same
  // counter state so they stay mutually aligned. Composite sync is the
  // XNOR of the two active-low syncs, i.e. hsync inverted during vsync.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vt.char_load   <= 1'b0;
      vt.vid_addr    <= '0;
      vt.scan_line   <= '0;
      vt.active_h    <= 1'b0;
      vt.active_v    <= 1'b0;
      vt.active      <= 1'b0;
      vt.hsync_n     <= 1'b1;
      vt.vsync_n     <= 1'b1;
      vt.csync_n     <= 1'b1;
      vt.frame_start <= 1'b0;
      vt.blink       <= 1'b0;
    end else begin
      vt.char_load   <= (cc == '0);
      vt.frame_start <= (cc == '0) && (hc == '0) && (vc == '0);
      vt.active_h    <= in_h;
      vt.active_v    <= in_v;
      vt.active      <= in_h && in_v;
      vt.vid_addr    <= (in_h && in_v) ? addr_next : '0;
      vt.scan_line   <= (in_h && in_v) ? 4'(scan) : '0;
      vt.hsync_n     <= ~in_hs;
      vt.vsync_n     <= ~in_vs;
      vt.csync_n     <= ~(in_hs ^ in_vs);
      vt.blink       <= blink_state;
    end
  end

endmodule

// File: tb/tb_nas_vid_timing.sv
// ---------------------------------------------------------------------------
// tb_nas_vid_timing
//   Scoreboard bench for nas_vid_timing. The raster is shrunk so that many
//   frames fit in a short run: 2 clks/char, 64 slots/line (48 active, hsync
//   slots 52..56), 3 scans x 4 rows = 12 active lines, 20 or 16 lines/frame,
//   vsync lines 14..15, stride 64, top row 3, blink half-period 2 frames.
//   Line = 128 clks, 50Hz frame = 2560 clks, 60Hz frame = 2048 clks.
//
//   The stimulus process pushes hand-computed expectations into three
//   queues (per-slot values, per-line stats, per-frame stats); the monitor
//   tracks raster position from char_load/frame_start and pops/compares.
// ---------------------------------------------------------------------------
module tb_nas_vid_timing;

  localparam int CPC = 2;
  localparam int HT  = 64;
  localparam int FRAME_BUDGET = 3000;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  nas_vid_timing_if vt ();

  nas_vid_timing #(
    .CLKS_PER_CHAR(CPC), .H_TOTAL(HT), .H_ACTIVE(48), .HSYNC_START(52), .HSYNC_WIDTH(5),
    .SCANS_PER_ROW(3), .ROWS(4), .V_TOTAL_50(20), .V_TOTAL_60(16),
    .VSYNC_START(14), .VSYNC_WIDTH(2), .ROW_STRIDE(64), .TOP_ROW(3), .BLINK_FRAMES(2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .vt      (vt)
  );

  typedef struct {
    int         line;
    int         slot;
    logic [9:0] addr;
    logic [3:0] scan;
    logic       act;
    logic       hs_n;
    logic       vs_n;
    logic       cs_n;
  } slot_exp_t;

  typedef struct {
    int line;
    int loads;
    int act_h_clks;
    int hs_low_clks;
    int hs_first;
  } line_exp_t;

  typedef struct {
    int   gap;
    int   act_lines;
    int   vs_lines;
    logic blink;
  } frame_exp_t;

  slot_exp_t  slot_q[$];
  line_exp_t  line_q[$];
  frame_exp_t frame_q[$];

  int applied     = 0;
  int miscompares = 0;

  // Every comparison funnels through here so both counters stay honest.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pushSlot(input int line, input int slot, input logic [9:0] addr,
                          input logic [3:0] scan, input logic act, hs_n, vs_n, cs_n);
    slot_exp_t e;
    e.line = line; e.slot = slot; e.addr = addr; e.scan = scan;
    e.act = act; e.hs_n = hs_n; e.vs_n = vs_n; e.cs_n = cs_n;
    slot_q.push_back(e);
  endtask

  task automatic pushLine(input int line);
    line_exp_t e;
    e.line = line; e.loads = 64; e.act_h_clks = 96; e.hs_low_clks = 10; e.hs_first = 52;
    line_q.push_back(e);
  endtask

  task automatic pushFrame(input int gap, input logic blink);
    frame_exp_t e;
    e.gap = gap; e.act_lines = 12; e.vs_lines = 2; e.blink = blink;
    frame_q.push_back(e);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_char_load"},   32'(vt.char_load),   0);
    checkOutput({tag, "_vid_addr"},    32'(vt.vid_addr),    0);
    checkOutput({tag, "_scan_line"},   32'(vt.scan_line),   0);
    checkOutput({tag, "_active_h"},    32'(vt.active_h),    0);
    checkOutput({tag, "_active_v"},    32'(vt.active_v),    0);
    checkOutput({tag, "_active"},      32'(vt.active),      0);
    checkOutput({tag, "_hsync_n"},     32'(vt.hsync_n),     1);
    checkOutput({tag, "_vsync_n"},     32'(vt.vsync_n),     1);
    checkOutput({tag, "_csync_n"},     32'(vt.csync_n),     1);
    checkOutput({tag, "_frame_start"}, 32'(vt.frame_start), 0);
    checkOutput({tag, "_blink"},       32'(vt.blink),       0);
  endtask

  task automatic waitFrameStart(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (vt.frame_start !== 1'b1 && n < FRAME_BUDGET);
    checkOutput({"fs_wait_", tag}, 32'(vt.frame_start), 1);
  endtask

  // Release reset just after an edge: the first edge moves the counters off
  // zero and registers frame_start/char_load high, the second drops them.
  task automatic releaseReset(input string tag);
    reset_n = 1'b1;
    @(posedge clk); #1;
    checkOutput({tag, "_fs_edge1"}, 32'(vt.frame_start), 1);
    checkOutput({tag, "_cl_edge1"}, 32'(vt.char_load),   1);
    @(posedge clk); #1;
    checkOutput({tag, "_fs_edge2"}, 32'(vt.frame_start), 0);
    checkOutput({tag, "_cl_edge2"}, 32'(vt.char_load),   0);
  endtask

  // ---------------------------------------------------------------- monitor
  int   cyc = 0;
  int   last_fs, mon_line, mon_slot;
  bit   pos_valid, fs_valid, line_valid, new_line;
  int   fr_act, fr_vs, ln_loads, ln_ah, ln_hsl, ln_hs_first;
  logic fr_blink;

  task automatic finishLine();
    line_exp_t e;
    if (line_q.size() > 0 && line_q[0].line == mon_line) begin
      e = line_q.pop_front();
      checkOutput($sformatf("line%0d_char_loads", e.line), 32'(ln_loads),    32'(e.loads));
      checkOutput($sformatf("line%0d_active_h",   e.line), 32'(ln_ah),       32'(e.act_h_clks));
      checkOutput($sformatf("line%0d_hsync_low",  e.line), 32'(ln_hsl),      32'(e.hs_low_clks));
      checkOutput($sformatf("line%0d_hsync_slot", e.line), 32'(ln_hs_first), 32'(e.hs_first));
    end
  endtask

  task automatic finishFrame();
    frame_exp_t e;
    if (frame_q.size() > 0) begin
      e = frame_q.pop_front();
      checkOutput("frame_gap",       32'(cyc - last_fs), 32'(e.gap));
      checkOutput("frame_act_lines", 32'(fr_act),        32'(e.act_lines));
      checkOutput("frame_vs_lines",  32'(fr_vs),         32'(e.vs_lines));
      checkOutput("frame_blink",     32'(fr_blink),      32'(e.blink));
    end else begin
      checkOutput("frame_unexpected", 32'(frame_q.size()), 1);
    end
  endtask

  task automatic checkSlot();
    slot_exp_t e;
    string     at;
    e  = slot_q.pop_front();
    at = $sformatf("@%0d.%0d", e.line, e.slot);
    checkOutput({"vid_addr", at},  32'(vt.vid_addr),  32'(e.addr));
    checkOutput({"scan_line", at}, 32'(vt.scan_line), 32'(e.scan));
    checkOutput({"active", at},    32'(vt.active),    32'(e.act));
    checkOutput({"hsync_n", at},   32'(vt.hsync_n),   32'(e.hs_n));
    checkOutput({"vsync_n", at},   32'(vt.vsync_n),   32'(e.vs_n));
    checkOutput({"csync_n", at},   32'(vt.csync_n),   32'(e.cs_n));
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (reset_n !== 1'b1) begin
        pos_valid  = 1'b0;
        fs_valid   = 1'b0;
        line_valid = 1'b0;
      end else begin
        if (vt.char_load === 1'b1) begin
          new_line = 1'b0;
          if (vt.frame_start === 1'b1) begin
            if (line_valid) finishLine();
            if (fs_valid) finishFrame();
            fs_valid  = 1'b1;
            last_fs   = cyc;
            fr_act    = 0;
            fr_vs     = 0;
            fr_blink  = vt.blink;
            pos_valid = 1'b1;
            mon_line  = 0;
            mon_slot  = 0;
            new_line  = 1'b1;
          end else if (pos_valid) begin
            mon_slot++;
            if (mon_slot == HT) begin
              if (line_valid) finishLine();
              mon_slot = 0;
              mon_line++;
              new_line = 1'b1;
            end
          end
          if (new_line) begin
            line_valid  = 1'b1;
            ln_loads    = 0;
            ln_ah       = 0;
            ln_hsl      = 0;
            ln_hs_first = -1;
            if (vt.active_v === 1'b1) fr_act++;
            if (vt.vsync_n === 1'b0) fr_vs++;
          end
          if (pos_valid && slot_q.size() > 0 &&
              slot_q[0].line == mon_line && slot_q[0].slot == mon_slot) begin
            checkSlot();
          end
        end
        if (line_valid) begin
          if (vt.char_load === 1'b1) ln_loads++;
          if (vt.active_h === 1'b1) ln_ah++;
          if (vt.hsync_n === 1'b0) begin
            ln_hsl++;
            if (ln_hs_first < 0) ln_hs_first = mon_slot;
          end
        end
      end
    end
  end

  // --------------------------------------------------------------- stimulus
  task automatic applyStimulus();
    reset_n     = 1'b0;
    vt.sel_60hz = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkReset("por");

    // First frame: addressing with top-row rotation, blanking, sync corners.
    pushSlot(0,  0,  10'h0C0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1);
    pushSlot(0,  51, 10'h000, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    pushSlot(3,  5,  10'h005, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1);
    pushSlot(4,  10, 10'h00A, 4'd1, 1'b1, 1'b1, 1'b1, 1'b1);
    pushSlot(6,  20, 10'h054, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1);
    pushSlot(7,  63, 10'h000, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    pushSlot(11, 47, 10'h0AF, 4'd2, 1'b1, 1'b1, 1'b1, 1'b1);
    pushSlot(12, 0,  10'h000, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    pushSlot(13, 0,  10'h000, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    pushSlot(14, 0,  10'h000, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    pushSlot(14, 52, 10'h000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    pushSlot(15, 56, 10'h000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    pushSlot(15, 57, 10'h000, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    pushSlot(16, 52, 10'h000, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    pushLine(0);
    pushLine(5);
    pushLine(14);
    pushLine(19);
    pushFrame(2560, 1'b0);
    pushFrame(2560, 1'b0);
    pushFrame(2560, 1'b1);

    releaseReset("rel0");
    waitFrameStart("f1");
    waitFrameStart("f2");

    // Mid-frame switch to 60Hz: frame 2 keeps 20 lines, frame 3 has 16.
    repeat (600) @(posedge clk);
    #1;
    vt.sel_60hz = 1'b1;
    pushFrame(2048, 1'b1);
    waitFrameStart("f3");
    waitFrameStart("f4");

    // Back to 50Hz mid-frame: frame 4 stays 16 lines.
    repeat (600) @(posedge clk);
    #1;
    vt.sel_60hz = 1'b0;
    pushFrame(2048, 1'b0);
    waitFrameStart("f5");

    // Reset around line 10 of frame 5; nothing of that frame may survive.
    repeat (1290) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    checkReset("mid");
    repeat (3) @(posedge clk);
    #1;
    checkReset("mid_hold");

    pushSlot(0, 0,  10'h0C0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1);
    pushSlot(4, 10, 10'h00A, 4'd1, 1'b1, 1'b1, 1'b1, 1'b1);
    pushFrame(2560, 1'b0);
    pushFrame(2560, 1'b0);
    pushFrame(2560, 1'b1);
    releaseReset("rel1");
    waitFrameStart("r1");
    waitFrameStart("r2");
    waitFrameStart("r3");

    repeat (4) @(posedge clk);
    #1;
    checkOutput("slot_q_left",  32'(slot_q.size()),  0);
    checkOutput("line_q_left",  32'(line_q.size()),  0);
    checkOutput("frame_q_left", 32'(frame_q.size()), 0);
  endtask

  initial begin
    applyStimulus();
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

endmodule
